// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the round-robin float-unit arbiter.
// Optional WAIT timeout is enabled by defining FPU_ARB_TIMEOUT_EN.
package fpu_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    // Quiet NaN for an IEEE format of width s (16/32/64): exponent ones plus mantissa MSB.
    function automatic logic [63:0] qnan_f(input int s);
        int          ew;
        logic [63:0] v;
        ew = (s == 16) ? 5 : (s == 64) ? 11 : 8;
        v  = '0;
        for (int i = 0; i < 64; i++) begin
            if (i >= s - 2 - ew && i <= s - 2) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping to 0.
// Used by fpu_arbiter; no configuration macros.
module rr_pick #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          valid
);

    always_comb begin
        win   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            int s;
            s = int'(ptr) + k;
            if (s >= N) s = s - N;
            if (!valid && req[PW'(s)]) begin
                win[PW'(s)] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one float unit among N requesters with round-robin arbitration.
// Define FPU_ARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles with a quiet NaN.
module fpu_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int S       = 32,
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [S*N-1:0] op_a,
    input  logic [S*N-1:0] op_b,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rsp_valid,
    output logic [S-1:0]   rsp_data,
    output logic           rsp_err,
    output logic           fu_rst_n,
    output logic           fu_start,
    output logic [S-1:0]   fu_a,
    output logic [S-1:0]   fu_b,
    input  logic [S-1:0]   fu_result,
    input  logic           fu_done,
    output logic           busy
);

    localparam int PW = $clog2(N);

    arb_state_e    state_q;
    logic [PW-1:0] ptr_q;
    logic [N-1:0]  win_q;
    logic [N-1:0]  gnt_q;
    logic [N-1:0]  rsp_valid_q;
    logic [S-1:0]  rsp_data_q;
    logic          fu_rst_n_q;
    logic          fu_start_q;
    logic [S-1:0]  fu_a_q;
    logic [S-1:0]  fu_b_q;
    logic          busy_q;

    logic [N-1:0]  pick;
    logic          pick_vld;
    logic [S-1:0]  sel_a_d;
    logic [S-1:0]  sel_b_d;
    logic [PW-1:0] ptr_d;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int          CW     = (TIMEOUT >= 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [63:0] QNAN64 = qnan_f(S);
    logic [CW-1:0] cnt_q;
    logic          rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign rsp_err        = 1'b0;
`endif

    rr_pick #(.N(N)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win   (pick),
        .valid (pick_vld)
    );

    always_comb begin
        sel_a_d = '0;
        sel_b_d = '0;
        ptr_d   = ptr_q;
        for (int i = 0; i < N; i++) begin
            if (pick[i]) begin
                sel_a_d = sel_a_d | op_a[S*i +: S];
                sel_b_d = sel_b_d | op_b[S*i +: S];
            end
            if (win_q[i]) ptr_d = (i == N - 1) ? '0 : PW'(i + 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            fu_rst_n_q  <= 1'b0;
            fu_start_q  <= 1'b0;
            fu_a_q      <= '0;
            fu_b_q      <= '0;
            busy_q      <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            fu_start_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        win_q      <= pick;
                        fu_a_q     <= sel_a_d;
                        fu_b_q     <= sel_b_d;
                        fu_rst_n_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= CLR;
                    end else begin
                        fu_rst_n_q <= 1'b1;
                    end
                end
                CLR: begin
                    fu_rst_n_q <= 1'b1;
                    // A winner that dropped its request before the grant is withdrawn.
                    if (|(req & win_q)) begin
                        fu_start_q <= 1'b1;
                        gnt_q      <= win_q;
                        state_q    <= ISSUE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                ISSUE: begin
`ifdef FPU_ARB_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (fu_done) begin
                        rsp_data_q  <= fu_result;
                        rsp_valid_q <= win_q;
                        state_q     <= RESP;
`ifdef FPU_ARB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_data_q  <= QNAN64[S-1:0];
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= win_q;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                RESP: begin
                    ptr_q   <= ptr_d;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign fu_rst_n  = fu_rst_n_q;
    assign fu_start  = fu_start_q;
    assign fu_a      = fu_a_q;
    assign fu_b      = fu_b_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter: directed scenarios plus randomized traffic.
// Timeout scenarios run only when FPU_ARB_TIMEOUT_EN is defined.
module tb_fpu_arbiter;

    localparam int S  = 32;
    localparam int N  = 4;
    localparam int PW = 2;
`ifdef FPU_ARB_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 255;
`endif
    localparam logic [S-1:0] QNAN = 32'h7FC0_0000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [S*N-1:0] op_a = '0, op_b = '0;
    logic [N-1:0]   gnt, rsp_valid;
    logic [S-1:0]   rsp_data;
    logic           rsp_err, fu_rst_n, fu_start, busy;
    logic [S-1:0]   fu_a, fu_b;
    logic [S-1:0]   fu_result = '0;
    logic           fu_done = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: pending requests, operands per requester, round-robin pointer.
    logic [N-1:0] pend = '0;
    logic [S-1:0] opa [N];
    logic [S-1:0] opb [N];
    int           mptr = 0;

    fpu_arbiter #(.S(S), .N(N), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .fu_rst_n  (fu_rst_n),
        .fu_start  (fu_start),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .fu_result (fu_result),
        .fu_done   (fu_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive();
        req = pend;
        for (int i = 0; i < N; i++) begin
            op_a[S*i +: S] = opa[i];
            op_b[S*i +: S] = opb[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            opa[i] = $urandom();
            opb[i] = $urandom();
        end
    endtask

    function automatic int pick(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (p[PW'(idx)]) return idx;
        end
        return 0;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_fu_start"}, fu_start, 0);
        chk({tag, "_fu_rst_n"}, fu_rst_n, 0);
        chk({tag, "_fu_a"}, fu_a, 0);
        chk({tag, "_fu_b"}, fu_b, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        fu_done = 1'b0;
        pend    = '0;
        drive();
        step();
        step();
        check_reset_vals("reset");
        rst  = 1'b0;
        mptr = 0;
    endtask

    // One full transaction starting at an IDLE negedge; d = WAIT cycles before done.
    task automatic run_op(input logic [N-1:0] add, input int d, input bit drop,
                          input logic [N-1:0] wd, input bit chg, input bit to,
                          input bit rst_wait);
        logic [PW-1:0] w;
        logic [N-1:0]  oh, keep;
        logic [S-1:0]  ea, eb, r;
        pend = pend | add;
        if (pend == '0) pend[PW'($urandom_range(0, N - 1))] = 1'b1;
        drive();
        w  = PW'(pick(pend, mptr));
        oh = N'(1) << w;
        ea = opa[w];
        eb = opb[w];
        r  = ea + eb;

        step();  // CLR
        chk("clr_busy", busy, 1);
        chk("clr_fu_rst_n", fu_rst_n, 0);
        chk("clr_fu_start", fu_start, 0);
        chk("clr_gnt", gnt, 0);
        chk("clr_rsp_valid", rsp_valid, 0);
        chk("latched_fu_a", fu_a, ea);
        chk("latched_fu_b", fu_b, eb);
        fu_done = 1'b0;

        step();  // ISSUE
        chk("issue_gnt", gnt, oh);
        chk("issue_fu_start", fu_start, 1);
        chk("issue_fu_rst_n", fu_rst_n, 1);

        step();  // WAIT, first cycle
        chk("wait_gnt", gnt, 0);
        chk("wait_fu_start", fu_start, 0);
        chk("wait_busy", busy, 1);
        keep    = ~wd;
        keep[w] = !drop;
        pend    = pend & keep;
        drive();

        if (rst_wait) begin
            rst = 1'b1;
            step();
            check_reset_vals("midop_reset");
            rst  = 1'b0;
            mptr = 0;
            return;
        end

        for (int i = 0; i < (to ? TO - 1 : d); i++) begin
            if (chg) begin
                rand_ops();
                drive();
            end
            step();
            chk("wait_no_rsp", rsp_valid, 0);
        end
        if (!to) begin
            fu_result = r;
            fu_done   = 1'b1;
        end

        step();  // RESP
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_data", rsp_data, to ? QNAN : r);
        chk("rsp_err", rsp_err, to ? 1 : 0);
        chk("rsp_gnt", gnt, 0);
        chk("hold_fu_a", fu_a, ea);
        chk("hold_fu_b", fu_b, eb);
        pend[w] = 1'b0;
        drive();

        step();  // back in IDLE; fu_done left high as a stale level
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_busy", busy, 0);
        mptr = (int'(w) + 1) % N;
    endtask

    initial begin
        rand_ops();
        do_reset();

        // Single requester 2 with fixed operands, done 3 cycles after start.
        opa[2] = 32'h3F80_0000;
        opb[2] = 32'h4000_0000;
        run_op(4'b0100, 2, 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Pointer now past requester 1; it must still win.
        run_op(4'b0010, 1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Reset in WAIT abandons the op; pointer returns to 0.
        run_op(4'b1000, 0, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // All four requesting continuously: 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            run_op(4'b1111, i, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        end

        // Requester 0 drops after its grant; requester 1 withdraws before being granted.
        do_reset();
        run_op(4'b0011, 1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
        run_op(4'b0100, 0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

`ifdef FPU_ARB_TIMEOUT_EN
        run_op(4'b0001, 0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        run_op(4'b0010, TO - 1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
`endif

        for (int i = 0; i < 30; i++) begin
            rand_ops();
            run_op(N'($urandom_range(0, 15)), $urandom_range(0, 6),
                   1'($urandom_range(0, 1)), N'($urandom() & $urandom()),
                   1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
